gray_updown_counter: RTL and testbench

//  Registered up/down Gray-code counter: successor to the combinational Gray incrementer.
//  - Adds direction control, synchronous load/clear and enable.
//  - Selectable wrap or saturate mode, terminal-count flag and wrap pulse.
//  - Mirrors the count in binary.
//  - Intended for CDC FIFO pointers and position counters; next-state logic uses

---
 rtl/gray_updown_counter.sv | 70 +++++++
 tb/tb_gray_updown_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_updown_counter.sv
// gray_updown_counter: registered up/down Gray counter with binary mirror, wrap/saturate modes,
// terminal-count flag and wrap pulse; next state uses parity plus a selectable prefix-AND tree.
module gray_updown_counter #(
   parameter int width   = 16,
   parameter int speed   = 1,
   parameter int SAT     = 0,
   parameter int RST_VAL = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             ld_i,
   input  logic [width-1:0] ld_val_i,
   input  logic             en_i,
   input  logic             dn_i,
   output logic [width-1:0] q_o,
   output logic [width-1:0] q_bin_o,
   output logic             tc_o,
   output logic             wrap_o
);
   localparam int n = width - 2;
   localparam int levels = $clog2(n);
   localparam logic [width-1:0] rst_bin = width'(RST_VAL);
   localparam logic [width-1:0] rst_gray = rst_bin ^ (rst_bin >> 1);
   logic [n-1:0] pre;
   logic [n:0] pz;
   logic [width-1:0] flip, d, d_bin;
   logic low_rule, step, wrap_d;
   // pre[j] = all of q_o[j:0] are zero, built serially, Brent-Kung or Sklansky
   always_comb begin
      pre = ~q_o[n-1:0];
      if (speed == 0) begin
         for (int i = 1; i < n; i++) pre[i] = pre[i] & pre[i-1];
      end else if (speed == 1) begin
         for (int l = 0; (1 << l) < n; l++)
            for (int i = 0; i < n; i++)
               if ((i + 1) % (2 << l) == 0) pre[i] = pre[i] & pre[i - (1 << l)];
         for (int l = levels - 2; l >= 0; l--)
            for (int i = 0; i < n; i++)
               if ((i + 1) % (2 << l) == (1 << l) && i >= (2 << l)) pre[i] = pre[i] & pre[i - (1 << l)];
      end else begin
         for (int l = 0; (1 << l) < n; l++)
            for (int i = 0; i < n; i++)
               if ((i & (1 << l)) != 0) pre[i] = pre[i] & pre[((i >> l) << l) - 1];
      end
      pz = {pre, 1'b1};
      low_rule = (^q_o) ^ dn_i;
      flip = '0;
      flip[0] = ~low_rule;
      for (int k = 1; k < width - 1; k++) flip[k] = low_rule & q_o[k-1] & pz[k-1];
      flip[width-1] = low_rule & pz[n];
      tc_o = dn_i ? (q_bin_o == '0) : (&q_bin_o);
      step = en_i && !((SAT != 0) && tc_o);
      wrap_d = !clr_i && !ld_i && en_i && tc_o && (SAT == 0);
      d = clr_i ? rst_gray : ld_i ? ld_val_i : step ? (q_o ^ flip) : q_o;
      d_bin[width-1] = d[width-1];
      for (int i = width - 2; i >= 0; i--) d_bin[i] = d_bin[i+1] ^ d[i];
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q_o <= rst_gray;
         q_bin_o <= rst_bin;
         wrap_o <= 1'b0;
      end else begin
         q_o <= d;
         q_bin_o <= d_bin;
         wrap_o <= wrap_d;
      end
   end
endmodule

// File: tb/tb_gray_updown_counter.sv
// tb_gray_updown_counter: directed width-4 scenarios plus a randomized run over a speed x width grid,
// each instance checked against a plain binary counter model.
module tb_gray_updown_counter;
   logic clk = 0, rst = 1, clr = 0, ld = 0, en = 0, dn = 0;
   logic [15:0] ld_val = '0;
   logic [3:0] q, qb, qs, qbs;
   logic tc, wrap, tcs, wraps;
   logic [15:0] rq [9];
   logic [15:0] rb [9];
   logic rt [9];
   logic rw [9];
   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   gray_updown_counter #(.width(4), .speed(1), .SAT(0), .RST_VAL(0)) u (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .ld_i(ld), .ld_val_i(ld_val[3:0]),
      .en_i(en), .dn_i(dn), .q_o(q), .q_bin_o(qb), .tc_o(tc), .wrap_o(wrap));
   gray_updown_counter #(.width(4), .speed(1), .SAT(1), .RST_VAL(0)) us (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .ld_i(ld), .ld_val_i(ld_val[3:0]),
      .en_i(en), .dn_i(dn), .q_o(qs), .q_bin_o(qbs), .tc_o(tcs), .wrap_o(wraps));

   for (genvar s = 0; s < 3; s++) begin : g_s
      for (genvar w = 0; w < 3; w++) begin : g_w
         localparam int wd = (w == 0) ? 3 : (w == 1) ? 8 : 16;
         logic [wd-1:0] gq, gb;
         logic gt, gw;
         gray_updown_counter #(.width(wd), .speed(s), .SAT(0), .RST_VAL((wd == 3) ? 3 : 5)) ug (
            .clk_i(clk), .rst_i(rst), .clr_i(clr), .ld_i(ld), .ld_val_i(ld_val[wd-1:0]),
            .en_i(en), .dn_i(dn), .q_o(gq), .q_bin_o(gb), .tc_o(gt), .wrap_o(gw));
         assign rq[s*3+w] = 16'(gq);
         assign rb[s*3+w] = 16'(gb);
         assign rt[s*3+w] = gt;
         assign rw[s*3+w] = gw;
      end
   end

   function automatic int wof(int g);
      return (g % 3 == 0) ? 3 : (g % 3 == 1) ? 8 : 16;
   endfunction
   function automatic int rvof(int g);
      return (wof(g) == 3) ? 3 : 5;
   endfunction
   function automatic logic [15:0] b2g(logic [15:0] b);
      return b ^ (b >> 1);
   endfunction
   function automatic logic [15:0] g2b(logic [15:0] g);
      logic [15:0] b = g;
      for (int sh = 1; sh < 16; sh <<= 1) b ^= b >> sh;
      return b;
   endfunction

   task automatic test_reset();
      en = 1; dn = 0;
      repeat (5) @(posedge clk);
      #2 rst = 1;
      #1;
      n_cmp += 3;
      if (q !== 4'b0000) begin n_bad++; $display("FAIL reset_q got %b want 0000", q); end
      if (qb !== 4'd0) begin n_bad++; $display("FAIL reset_qbin got %0d want 0", qb); end
      if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got %b want 0", wrap); end
      for (int g = 0; g < 9; g++) begin
         n_cmp += 2;
         if (rb[g] !== 16'(rvof(g))) begin n_bad++; $display("FAIL reset_grid%0d_bin got %0d want %0d", g, rb[g], rvof(g)); end
         if (rq[g] !== b2g(16'(rvof(g)))) begin n_bad++; $display("FAIL reset_grid%0d_q got %h want %h", g, rq[g], b2g(16'(rvof(g)))); end
      end
      en = 0;
      #1 rst = 0;
   endtask

   task automatic test_up();
      logic [3:0] prev;
      int b = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 17; i++) begin
         en = 1; dn = 0; prev = q;
         #1;
         n_cmp++;
         if (tc !== (b == 15)) begin n_bad++; $display("FAIL up_tc step%0d got %b want %b", i, tc, b == 15); end
         @(posedge clk); #1;
         n_cmp += 4;
         if (wrap !== (b == 15)) begin n_bad++; $display("FAIL up_wrap step%0d got %b want %b", i, wrap, b == 15); end
         b = (b + 1) % 16;
         if (qb !== 4'(b)) begin n_bad++; $display("FAIL up_qbin step%0d got %0d want %0d", i, qb, b); end
         if (q !== 4'(b2g(16'(b)))) begin n_bad++; $display("FAIL up_q step%0d got %b want %b", i, q, 4'(b2g(16'(b)))); end
         if ($countones(q ^ prev) != 1) begin n_bad++; $display("FAIL up_onebit step%0d got %b want one-bit change from %b", i, q, prev); end
      end
      en = 0;
   endtask

   task automatic test_load_down();
      ld = 1; ld_val = 16'b0110;
      @(posedge clk); #1;
      n_cmp += 3;
      if (q !== 4'b0110) begin n_bad++; $display("FAIL ld_q got %b want 0110", q); end
      if (qb !== 4'd4) begin n_bad++; $display("FAIL ld_qbin got %0d want 4", qb); end
      if (wrap !== 1'b0) begin n_bad++; $display("FAIL ld_wrap got %b want 0", wrap); end
      ld = 0; en = 1; dn = 1;
      @(posedge clk); #1;
      n_cmp += 2;
      if (q !== 4'b0010) begin n_bad++; $display("FAIL dn_q got %b want 0010", q); end
      if (qb !== 4'd3) begin n_bad++; $display("FAIL dn_qbin got %0d want 3", qb); end
      clr = 1; ld = 1; ld_val = 16'b1111;
      @(posedge clk); #1;
      n_cmp += 2;
      if (q !== 4'b0000) begin n_bad++; $display("FAIL clr_over_ld_q got %b want 0000", q); end
      if (qb !== 4'd0) begin n_bad++; $display("FAIL clr_over_ld_qbin got %0d want 0", qb); end
      clr = 0; ld = 0; en = 0; dn = 0;
   endtask

   task automatic test_saturate();
      ld = 1; ld_val = 16'b1000;
      @(posedge clk); #1;
      ld = 0;
      n_cmp++;
      if (qbs !== 4'd15) begin n_bad++; $display("FAIL sat_ld_qbin got %0d want 15", qbs); end
      for (int i = 0; i < 3; i++) begin
         en = 1; dn = 0;
         #1;
         n_cmp++;
         if (tcs !== 1'b1) begin n_bad++; $display("FAIL sat_tc step%0d got %b want 1", i, tcs); end
         @(posedge clk); #1;
         n_cmp += 3;
         if (qs !== 4'b1000) begin n_bad++; $display("FAIL sat_q step%0d got %b want 1000", i, qs); end
         if (qbs !== 4'd15) begin n_bad++; $display("FAIL sat_qbin step%0d got %0d want 15", i, qbs); end
         if (wraps !== 1'b0) begin n_bad++; $display("FAIL sat_wrap step%0d got %b want 0", i, wraps); end
      end
      dn = 1;
      @(posedge clk); #1;
      n_cmp += 2;
      if (qs !== 4'b1001) begin n_bad++; $display("FAIL sat_dn_q got %b want 1001", qs); end
      if (qbs !== 4'd14) begin n_bad++; $display("FAIL sat_dn_qbin got %0d want 14", qbs); end
      en = 0; dn = 0;
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_q [3] = '{4'b1000, 4'b0000, 4'b1000};
      logic dirs [3] = '{1'b1, 1'b0, 1'b1};
      clr = 1;
      @(posedge clk); #1;
      clr = 0;
      for (int i = 0; i < 3; i++) begin
         en = 1; dn = dirs[i];
         @(posedge clk); #1;
         n_cmp += 2;
         if (q !== exp_q[i]) begin n_bad++; $display("FAIL b2b_q step%0d got %b want %b", i, q, exp_q[i]); end
         if (wrap !== 1'b1) begin n_bad++; $display("FAIL b2b_wrap step%0d got %b want 1", i, wrap); end
      end
      en = 0;
      @(posedge clk); #1;
      n_cmp++;
      if (wrap !== 1'b0) begin n_bad++; $display("FAIL b2b_wrap_idle got %b want 0", wrap); end
   endtask

   task automatic test_random();
      int unsigned mb [9];
      logic mw [9];
      int unsigned m;
      clr = 1;
      @(posedge clk); #1;
      for (int g = 0; g < 9; g++) begin mb[g] = rvof(g); mw[g] = 0; end
      for (int c = 0; c < 10000 && n_bad < 20; c++) begin
         clr = ($urandom_range(63) == 0);
         ld = ($urandom_range(15) == 0);
         en = ($urandom_range(3) != 0);
         dn = $urandom_range(1);
         ld_val = 16'($urandom);
         #1;
         for (int g = 0; g < 9; g++) begin
            m = (1 << wof(g)) - 1;
            n_cmp++;
            if (rt[g] !== (dn ? mb[g] == 0 : mb[g] == m)) begin
               n_bad++; $display("FAIL rnd_tc grid%0d cyc%0d got %b want %b", g, c, rt[g], dn ? mb[g] == 0 : mb[g] == m);
            end
            mw[g] = 0;
            if (clr) mb[g] = rvof(g);
            else if (ld) mb[g] = g2b(ld_val & 16'(m));
            else if (en && dn) begin
               if (mb[g] == 0) begin mb[g] = m; mw[g] = 1; end else mb[g] = mb[g] - 1;
            end else if (en) begin
               if (mb[g] == m) begin mb[g] = 0; mw[g] = 1; end else mb[g] = mb[g] + 1;
            end
         end
         @(posedge clk); #1;
         for (int g = 0; g < 9; g++) begin
            n_cmp += 3;
            if (rb[g] !== 16'(mb[g])) begin n_bad++; $display("FAIL rnd_qbin grid%0d cyc%0d got %0d want %0d", g, c, rb[g], mb[g]); end
            if (rq[g] !== b2g(16'(mb[g]))) begin n_bad++; $display("FAIL rnd_q grid%0d cyc%0d got %h want %h", g, c, rq[g], b2g(16'(mb[g]))); end
            if (rw[g] !== mw[g]) begin n_bad++; $display("FAIL rnd_wrap grid%0d cyc%0d got %b want %b", g, c, rw[g], mw[g]); end
         end
      end
      clr = 0; ld = 0; en = 0; dn = 0;
   endtask

   initial begin
      #12 rst = 0;
      test_reset();
      test_up();
      test_load_down();
      test_saturate();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
